// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq
//   Byte-serial load/store sequencer between the core's memory stage and a
//   byte-wide data memory. One RV32I load or store is accepted at a time. It is
//   split into 1, 2 or 4 little-endian byte beats, one beat per cycle. Load data
//   is assembled and then sign- or zero-extended. Misaligned or illegal
//   requests are answered with resp_err and never touch memory.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : request handshake; the core holds the request until ready
//   req_store       : 1 = store, 0 = load
//   req_func3       : RV32I width/sign encoding (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr        : byte address (8 bit)
//   req_wdata       : store data, low byte goes out first
//   resp_done       : one-cycle completion pulse
//   resp_err        : misaligned/illegal request, valid with resp_done
//   resp_rdata      : extended load data (0 for stores/errors), valid with resp_done
//   mem_addr/re/we  : byte memory address and strobes for the current beat
//   mem_wdata       : byte being written
//   mem_rdata       : combinational read data for mem_addr
module lsu_byte_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [7:0]  mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_r;
    logic        store_r;
    logic [2:0]  func3_r;
    logic [1:0]  beat_r;
    logic [31:0] wdata_r;   // store data, shifted right one byte per beat
    logic [31:0] rdata_r;   // load assembly register

    logic [31:0] asm_s;     // assembly register with this beat's byte merged in
    logic        last_s;
    logic        legal_s;

    // Legality of a request: alignment and func3 encodings valid for the direction
    function automatic logic req_legal(input logic store, input logic [2:0] f3,
                                       input logic [7:0] addr);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (addr[0] == 1'b0);
            3'b010:  ok = (addr[1:0] == 2'b00);
            3'b100:  ok = !store;
            3'b101:  ok = !store && (addr[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Index of the final beat: 0 for byte, 1 for halfword, 3 for word
    function automatic logic [1:0] last_beat(input logic [2:0] f3);
        logic [1:0] lb;
        case (f3[1:0])
            2'b00:   lb = 2'd0;
            2'b01:   lb = 2'd1;
            2'b10:   lb = 2'd3;
            default: lb = 2'd0;
        endcase
        return lb;
    endfunction

    // Sign/zero extension of assembled load data
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b010:  r = d;
            3'b100:  r = {24'h000000, d[7:0]};
            3'b101:  r = {16'h0000, d[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Merge the byte returned by memory into its lane, and decode the request
    always_comb begin
        asm_s = rdata_r;
        case (beat_r)
            2'd0:    asm_s[7:0]   = mem_rdata;
            2'd1:    asm_s[15:8]  = mem_rdata;
            2'd2:    asm_s[23:16] = mem_rdata;
            2'd3:    asm_s[31:24] = mem_rdata;
            default: asm_s = rdata_r;
        endcase
        last_s  = (beat_r == last_beat(func3_r));
        legal_s = req_legal(req_store, req_func3, req_addr);
    end

    // Sequencer FSM; every output is registered and set up for the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            store_r    <= 1'b0;
            func3_r    <= 3'b000;
            beat_r     <= 2'd0;
            wdata_r    <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            req_ready  <= 1'b1;
            resp_done  <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_addr   <= 8'h00;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (legal_s) begin
                            state_r   <= ST_ACCESS;
                            store_r   <= req_store;
                            func3_r   <= req_func3;
                            beat_r    <= 2'd0;
                            wdata_r   <= req_wdata;
                            rdata_r   <= 32'h0000_0000;
                            mem_addr  <= req_addr;
                            mem_re    <= !req_store;
                            mem_we    <= req_store;
                            mem_wdata <= req_store ? req_wdata[7:0] : 8'h00;
                        end else begin
                            // Rejected request goes straight to the response
                            state_r    <= ST_RESP;
                            resp_done  <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0000_0000;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    rdata_r <= asm_s;
                    if (last_s) begin
                        state_r    <= ST_RESP;
                        mem_addr   <= 8'h00;
                        mem_re     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wdata  <= 8'h00;
                        resp_done  <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= store_r ? 32'h0000_0000 : extend(func3_r, asm_s);
                    end else begin
                        beat_r    <= beat_r + 2'd1;
                        mem_addr  <= mem_addr + 8'd1;
                        mem_wdata <= store_r ? wdata_r[15:8] : 8'h00;
                        wdata_r   <= {8'h00, wdata_r[31:8]};
                    end
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    beat_r     <= 2'd0;
                    req_ready  <= 1'b1;
                    resp_done  <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0000_0000;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    beat_r     <= 2'd0;
                    req_ready  <= 1'b1;
                    resp_done  <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0000_0000;
                    mem_addr   <= 8'h00;
                    mem_re     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_wdata  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed testbench for lsu_byte_seq with a byte-wide memory model.
module tb_lsu_byte_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_func3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];
    logic [15:0] wlog [64];    // {addr, data} of every write, in order
    int          wcnt;
    logic        mem_clr;

    int n_tests;
    int n_fail;

    lsu_byte_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_done  (resp_done),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory model: writes on the rising edge and logs them
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            wcnt <= 0;
        end else if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            wlog[wcnt[5:0]]   <= {mem_addr, mem_wdata};
            wcnt              <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then check latency, error flag, data and strobe count
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [7:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        int strb;
        lat  = 0;
        strb = 0;
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_store = st;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (resp_done) begin
                lat = i;
                break;
            end
            if (mem_re || mem_we) strb++;
            @(posedge clk);
            #1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_strb"}, strb, exp_err ? 0 : exp_lat - 1);
        @(posedge clk);
        #1;
        check({tag, "_done_end"}, {31'd0, resp_done}, 32'd0);
        check({tag, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic set_hold(input int k);
        req_store = (k % 2 == 0);
        req_func3 = 3'b000;
        req_addr  = 8'hFF;
        req_wdata = (k < 2) ? 32'h0000_005A : 32'h0000_00A5;
    endtask

    initial begin
        int w0;
        int s;
        int n;
        int nr;
        int acc [8];
        logic [31:0] rsp [8];
        logic pend;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        mem_clr   = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_func3 = 3'b000;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Reset values
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {30'd0, resp_done, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem", {14'd0, mem_addr, mem_wdata, mem_re, mem_we}, 32'd0);

        // Idle: no strobes
        s = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mem_re || mem_we || resp_done) s++;
        end
        check("idle_strb", s, 0);

        // Word store and its byte sequence
        w0 = wcnt;
        do_req("sw", 1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF, 5, 1'b0, 32'h0);
        check("sw_wcnt", wcnt - w0, 4);
        check("sw_w0", {16'd0, wlog[w0]},     {16'd0, 8'h10, 8'hEF});
        check("sw_w1", {16'd0, wlog[w0 + 1]}, {16'd0, 8'h11, 8'hBE});
        check("sw_w2", {16'd0, wlog[w0 + 2]}, {16'd0, 8'h12, 8'hAD});
        check("sw_w3", {16'd0, wlog[w0 + 3]}, {16'd0, 8'h13, 8'hDE});

        // Loads of the stored word
        do_req("lw",  1'b0, 3'b010, 8'h10, 32'h0, 5, 1'b0, 32'hDEAD_BEEF);
        do_req("lh",  1'b0, 3'b001, 8'h10, 32'h0, 3, 1'b0, 32'hFFFF_BEEF);
        do_req("lhu", 1'b0, 3'b101, 8'h10, 32'h0, 3, 1'b0, 32'h0000_BEEF);
        do_req("lb",  1'b0, 3'b000, 8'h13, 32'h0, 2, 1'b0, 32'hFFFF_FFDE);
        do_req("lbu", 1'b0, 3'b100, 8'h13, 32'h0, 2, 1'b0, 32'h0000_00DE);

        // Misaligned and illegal requests
        w0 = wcnt;
        do_req("err_lw",  1'b0, 3'b010, 8'h06, 32'h0,         1, 1'b1, 32'h0);
        do_req("err_sh",  1'b1, 3'b001, 8'h03, 32'h1234_5678, 1, 1'b1, 32'h0);
        do_req("err_l11", 1'b0, 3'b011, 8'h00, 32'h0,         1, 1'b1, 32'h0);
        do_req("err_s4",  1'b1, 3'b100, 8'h00, 32'h1234_5678, 1, 1'b1, 32'h0);
        check("err_wcnt", wcnt - w0, 0);

        // Reset during the second beat of a word store
        w0 = wcnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 8'h20;
        req_wdata = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_strb", {30'd0, mem_re, mem_we}, 32'd0);
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        s = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_re || mem_we || resp_done) s++;
        end
        check("rstmid_quiet", s, 0);
        check("rstmid_wcnt", wcnt - w0, 2);
        check("rstmid_w0", {16'd0, wlog[w0]},     {16'd0, 8'h20, 8'h44});
        check("rstmid_w1", {16'd0, wlog[w0 + 1]}, {16'd0, 8'h21, 8'h33});
        check("rstmid_m22", {24'd0, mem[8'h22]}, 32'd0);

        // req_valid held high: SB, LB, SB, LB to 0xFF
        n    = 0;
        nr   = 0;
        pend = 1'b0;
        @(negedge clk);
        set_hold(0);
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (n < 4) set_hold(n);
                else req_valid = 1'b0;
            end
            if (req_valid && req_ready && n < 8) begin
                acc[n] = cyc;
                n++;
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (resp_done && nr < 8) begin
                rsp[nr] = resp_rdata;
                nr++;
            end
        end
        check("hold_nacc", n, 4);
        check("hold_nrsp", nr, 4);
        if (n == 4) begin
            check("hold_gap1", acc[1] - acc[0], 3);
            check("hold_gap2", acc[2] - acc[1], 3);
            check("hold_gap3", acc[3] - acc[2], 3);
        end
        if (nr == 4) begin
            check("hold_sb0", rsp[0], 32'h0);
            check("hold_lb1", rsp[1], 32'h0000_005A);
            check("hold_lb3", rsp[3], 32'hFFFF_FFA5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
